// File: rtl/minmax_scan_ctrl.sv
// minmax_scan_ctrl
// Scans a burst of N_SAMPLES unsigned samples and reports the largest and smallest
// values with the index of their first occurrence. It uses one external magnitude
// comparator, shared between the max check and the min check of each sample.
module minmax_scan_ctrl #(
  parameter int WIDTH     = 4,
  parameter int N_SAMPLES = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] max_val,
  output logic [CNT_W-1:0] max_idx,
  output logic [WIDTH-1:0] min_val,
  output logic [CNT_W-1:0] min_idx
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_IN = 3'd1,
    S_CMP_MAX = 3'd2,
    S_CMP_MIN = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] samp;
  logic             hs;
  logic             single;

  // A burst of one sample finishes as soon as that sample is taken.
  assign single = (N_SAMPLES == 1);
  assign hs     = in_valid && in_ready;

  // State register. in_ready is registered from the next state so that the
  // handshake qualifier comes straight off a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == S_WAIT_IN);
    end
  end

  // Next-state decode: one wait for data, then the max and min checks on the shared comparator.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_WAIT_IN;
      S_WAIT_IN: begin
        if (hs) begin
          if (cnt == '0) state_nxt = single ? S_DONE : S_WAIT_IN;
          else           state_nxt = S_CMP_MAX;
        end
      end
      S_CMP_MAX: state_nxt = S_CMP_MIN;
      S_CMP_MIN: state_nxt = (cnt == LAST_IDX) ? S_DONE : S_WAIT_IN;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output decode: status flags and the comparator operands for the current check.
  always_comb begin
    busy  = (state != S_IDLE);
    done  = (state == S_DONE);
    cmp_a = '0;
    cmp_b = '0;
    case (state)
      S_CMP_MAX: begin
        cmp_a = samp;
        cmp_b = max_val;
      end
      S_CMP_MIN: begin
        cmp_a = samp;
        cmp_b = min_val;
      end
      default: ;
    endcase
  end

  // Sample counter, held sample and running results. Strict compares keep the earliest index on ties.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      samp    <= '0;
      max_val <= '0;
      max_idx <= '0;
      min_val <= '0;
      min_idx <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) cnt <= '0;
        S_WAIT_IN: begin
          if (hs) begin
            if (cnt == '0) begin
              max_val <= in_data;
              min_val <= in_data;
              max_idx <= '0;
              min_idx <= '0;
              cnt     <= ONE;
            end else begin
              samp <= in_data;
            end
          end
        end
        S_CMP_MAX: begin
          if (cmp_gt) begin
            max_val <= samp;
            max_idx <= cnt;
          end
        end
        S_CMP_MIN: begin
          if (cmp_lt) begin
            min_val <= samp;
            min_idx <= cnt;
          end
          if (cnt != LAST_IDX) cnt <= cnt + ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_minmax_scan_ctrl.sv
// tb_minmax_scan_ctrl
// Drives random and directed bursts into minmax_scan_ctrl and compares the results
// against a plain max/min search over the same burst.
module tb_minmax_scan_ctrl;

  localparam int N = 8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic [3:0] cmp_a;
  logic [3:0] cmp_b;
  logic       cmp_gt;
  logic       cmp_lt;
  logic       busy;
  logic       done;
  logic [3:0] max_val;
  logic [3:0] max_idx;
  logic [3:0] min_val;
  logic [3:0] min_idx;

  int total = 0;
  int bad   = 0;

  logic [3:0] smp [N];
  // Results the DUT is expected to hold between scans.
  logic [3:0] r_mx, r_mxi, r_mn, r_mni;

  minmax_scan_ctrl #(.WIDTH(4), .N_SAMPLES(N), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
    .busy(busy), .done(done), .max_val(max_val), .max_idx(max_idx),
    .min_val(min_val), .min_idx(min_idx)
  );

  // Behavioural stand-in for the shared 4-bit magnitude comparator.
  assign cmp_gt = (cmp_a > cmp_b);
  assign cmp_lt = (cmp_a < cmp_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " max_val"}, max_val, 0);
    check({tag, " max_idx"}, max_idx, 0);
    check({tag, " min_val"}, min_val, 0);
    check({tag, " min_idx"}, min_idx, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " in_ready"}, in_ready, 0);
    check({tag, " cmp_a"}, cmp_a, 0);
    check({tag, " cmp_b"}, cmp_b, 0);
  endtask

  // Plain search: first occurrence of the largest and smallest value.
  task automatic ref_scan(output logic [3:0] mx, output logic [3:0] mxi,
                          output logic [3:0] mn, output logic [3:0] mni);
    mx = smp[0]; mxi = 0; mn = smp[0]; mni = 0;
    for (int i = 1; i < N; i++) begin
      if (smp[i] > mx) begin mx = smp[i]; mxi = 4'(i); end
      if (smp[i] < mn) begin mn = smp[i]; mni = 4'(i); end
    end
  endtask

  // One scan starting at a negedge. gaps randomises in_valid; poke_at raises start
  // mid-scan on that cycle; abort_at pulls reset once that many samples are taken.
  task automatic run_scan(input string tag, input bit gaps, input int poke_at, input int abort_at);
    logic [3:0] emx, emxi, emn, emni;
    int acc;
    bit seen;
    int cyc;
    ref_scan(emx, emxi, emn, emni);
    start    = 1'b1;
    in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
    in_data  = smp[0];
    acc  = 0;
    seen = 0;
    cyc  = 0;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = (poke_at == cyc);
      if (abort_at > 0 && acc == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        check_cleared({tag, " abort"});
        rst_n    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        r_mx = 0; r_mxi = 0; r_mn = 0; r_mni = 0;
        return;
      end
      if (acc == 0) begin
        check({tag, " hold max_val"}, max_val, r_mx);
        check({tag, " hold min_val"}, min_val, r_mn);
      end
      if (done) begin
        seen = 1;
        check({tag, " max_val"}, max_val, emx);
        check({tag, " max_idx"}, max_idx, emxi);
        check({tag, " min_val"}, min_val, emn);
        check({tag, " min_idx"}, min_idx, emni);
        check({tag, " taken"}, acc, N);
        if (!gaps) check({tag, " done latency"}, cyc, 3 * N - 1);
      end else begin
        check({tag, " busy"}, busy, 1);
      end
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = (acc < N) ? smp[acc] : 4'($urandom_range(0, 15));
      if (in_valid && in_ready) acc++;
    end
    if (!seen) check({tag, " done timeout"}, 0, 1);
    start = 1'b0;
    @(negedge clk);
    check({tag, " done pulse"}, done, 0);
    check({tag, " idle busy"}, busy, 0);
    check({tag, " idle in_ready"}, in_ready, 0);
    check({tag, " idle cmp_a"}, cmp_a, 0);
    check({tag, " held max_val"}, max_val, emx);
    check({tag, " held min_idx"}, min_idx, emni);
    r_mx = emx; r_mxi = emxi; r_mn = emn; r_mni = emni;
  endtask

  task automatic load(input logic [31:0] packed_smp);
    for (int i = 0; i < N; i++) smp[i] = packed_smp[4*(N-1-i) +: 4];
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 4'hA;
    r_mx = 0; r_mxi = 0; r_mn = 0; r_mni = 0;

    // Reset held two cycles with start and in_valid active.
    @(negedge clk);
    @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_cleared("post reset");

    // Mixed burst with in_valid always high.
    load(32'h391_9F07F);
    run_scan("mixed", 0, 0, 0);
    check("mixed const max_val", max_val, 4'hF);
    check("mixed const max_idx", max_idx, 4);
    check("mixed const min_val", min_val, 4'h0);
    check("mixed const min_idx", min_idx, 5);

    // All samples equal: earliest index wins.
    load(32'h5555_5555);
    run_scan("ties", 0, 0, 0);
    check("ties const max_idx", max_idx, 0);
    check("ties const min_idx", min_idx, 0);
    check("ties const val", {max_val, min_val}, 8'h55);

    // start raised mid-scan is ignored.
    load(32'h2C4E_1736);
    run_scan("poke", 0, 7, 0);

    // Reset after four samples, then a fresh scan.
    load(32'hF0A1_B2C3);
    run_scan("abort", 0, 0, 4);
    @(negedge clk);
    load(32'h8263_8547);
    run_scan("fresh", 0, 0, 0);
    check("fresh const max", {max_val, max_idx}, 8'h80);
    check("fresh const min", {min_val, min_idx}, 8'h21);

    // Back-to-back scans: start on the cycle after done.
    load(32'h1234_5678);
    run_scan("b2b first", 0, 0, 0);
    load(32'h9A9A_3B3B);
    run_scan("b2b second", 0, 0, 0);

    // Random bursts with random in_valid gaps.
    for (int b = 0; b < 200; b++) begin
      for (int i = 0; i < N; i++)
        smp[i] = (b % 2 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      run_scan("random", 1, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
